pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the per-register `stall`/`flush` controls of IF/ID, ID/EX, EX/MEM and MEM/WB, and the PC hold. It also sequences the data-memory handshake for the instruction in MEM, which includes the wait-state and timeout handling. It sits beside the pipeline registers, and every hazard decision in the core goes through it.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum dmem wait cycles before abort (2..255).
- `CNT_W`, default 16: width of the stall-cycle performance counter.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ID_rs`, `ID_rt` in 5: source register numbers of the instruction in ID.
- `ID_uses_rs`, `ID_uses_rt` in 1: the ID instruction reads `rs`/`rt`.
- `EX_memtoreg` in 1: the EX instruction is a load.
- `EX_regwrite` in 1: the EX instruction writes a register.
- `EX_wraddr` in 5: destination register of the EX instruction.
- `EX_branch_taken` in 1: the branch/jump resolved in EX is taken.
- `MEM_memread`, `MEM_memwrite` in 1: the MEM instruction accesses dmem.
- `dmem_ack` in 1: dmem completes the access this cycle.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `pc_stall` out 1: hold the PC.
- `stall_ifid`, `stall_idex`, `stall_exmem`, `stall_memwb` out 1: hold the register.
- `flush_ifid`, `flush_idex`, `flush_memwb` out 1: load NOP into the register.
- `dmem_req` out 1: dmem access request.
- `bus_err` out 1: sticky, set when a dmem access times out.
- `stall_cnt` out CNT_W: count of cycles with `pc_stall`=1, saturating.

## Operation
- FSM states are IDLE and WAIT. The wait counter `wcnt` is 8 bits.
- `mem_acc` = `MEM_memread` | `MEM_memwrite`. `dmem_req` = `mem_acc` in both states. It is forced to 0 after a timeout until the next edge.
- IDLE:
  - `mem_acc` & !`dmem_ack` → WAIT, with `wcnt`=1.
  - `mem_acc` & `dmem_ack` is a zero-wait access. No stall; stay in IDLE.
- WAIT:
  - `dmem_ack`=1 → IDLE. Stalls are released in the same cycle, so the pipeline advances on that edge.
  - `wcnt`==`TIMEOUT` & !`dmem_ack` → IDLE. `dmem_req`=0, `bus_err` is set, `flush_memwb`=1 (the faulting access does not write back), and stalls are released.
  - Otherwise `wcnt`++.
- Memstall (`memstall`) is asserted when (IDLE & `mem_acc` & !`dmem_ack`) or (WAIT & !`dmem_ack` & `wcnt`!=`TIMEOUT`). While it is asserted:
  - `pc_stall`, `stall_ifid`, `stall_idex` and `stall_exmem` are 1.
  - `flush_memwb`=1, so a bubble goes into WB and stale data is never written twice.
  - All other flushes are 0.
- Load-use (`lu`) is `EX_memtoreg` & `EX_regwrite` & `EX_wraddr`!=0 & ((`ID_uses_rs` & `ID_rs`==`EX_wraddr`) | (`ID_uses_rt` & `ID_rt`==`EX_wraddr`)). Its outputs are `pc_stall`=1, `stall_ifid`=1, `flush_idex`=1.
- Taken branch (`br`) is `EX_branch_taken`. Its outputs are `flush_ifid`=1 and `flush_idex`=1, with no stalls.
- Priority is memstall > br > lu:
  - memstall masks br and lu. EX is frozen, so the branch is re-evaluated after release.
  - br masks lu, because the dependent instruction is squashed anyway.
- A stall and a flush are never both asserted on the same register.
- `stall_memwb` is always 0. The output is reserved for future use.
- `stall_cnt`:
  - Increments by 1 in each cycle where `pc_stall`=1, saturating at all-ones.
  - `cnt_clr` has priority over increment.
- `bus_err`: cleared only by reset.

## Timing
- All stall/flush outputs and `dmem_req` are combinational from the current state and inputs. Controlled registers act on the next `clk` edge.
- Load-use gives exactly 1 bubble cycle: the next cycle `EX_memtoreg`=0, so `lu` clears.
- Branch penalty: 2 flushed slots, decided in 1 cycle.
- An N-cycle memory latency (ack in the Nth request cycle, N≤`TIMEOUT`) gives N-1 stall cycles.
- Timeout: the abort happens in request cycle `TIMEOUT`+1, which is the first cycle with `wcnt`==`TIMEOUT`. Stall lasts `TIMEOUT` cycles.
- Reset asserted, including mid-WAIT:
  - State goes to IDLE, `wcnt`=0, `bus_err`=0, `stall_cnt`=0.
  - All outputs are 0 while `rst_n`=0, including `dmem_req`.
- An ack arriving in the same cycle as the timeout compare counts as success: no error, no flush.

## Test plan
- Load `r5` in EX with `ID_rs`=5 and `ID_uses_rs`=1. Expect `pc_stall`, `stall_ifid` and `flush_idex` to be 1 for exactly 1 cycle and `stall_cnt`=1. Repeat with `EX_wraddr`=0: expect no stall.
- `EX_branch_taken`=1 together with a load-use condition. Expect `flush_ifid`=`flush_idex`=1 and `pc_stall`=0.
- `MEM_memread`=1 with `dmem_ack` arriving in the 4th request cycle. Expect 3 stall cycles with `flush_memwb`=1, release in cycle 4 with `dmem_req` still high, and `stall_cnt`=3.
- `TIMEOUT`=4, `mem_acc` held, no ack:
  - 4 stall cycles.
  - In cycle 5: `dmem_req`=0, `flush_memwb`=1, `bus_err` rises and stays high.
  - Repeat with ack in cycle 5: expect `bus_err`=0.
- Memstall active while `EX_branch_taken`=1. Expect no flush_ifid/idex during the stall; both assert in the cycle after ack if the branch input is still 1.
- Assert `rst_n` low in the middle of WAIT. Expect all outputs 0 immediately and the FSM in IDLE. Set `stall_cnt` to all-ones, then apply more stalls: it holds. Then `cnt_clr`: expect 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, including the
// data-memory wait-state/timeout sequencer and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             EX_memtoreg,
    input  logic             EX_regwrite,
    input  logic [4:0]       EX_wraddr,
    input  logic             EX_branch_taken,
    input  logic             MEM_memread,
    input  logic             MEM_memwrite,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             stall_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_memwb,
    output logic             dmem_req,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] WLIMIT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wcnt;

    logic mem_acc;
    logic at_limit;
    logic timeout;
    logic memstall;
    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic br;

    always_comb begin
        mem_acc  = MEM_memread | MEM_memwrite;
        at_limit = (state == S_WAIT) && (wcnt == WLIMIT);
        timeout  = at_limit && !dmem_ack;
        memstall = ((state == S_IDLE) && mem_acc && !dmem_ack) ||
                   ((state == S_WAIT) && !dmem_ack && !at_limit);
        rs_hit   = ID_uses_rs && (ID_rs == EX_wraddr);
        rt_hit   = ID_uses_rt && (ID_rt == EX_wraddr);
        lu       = EX_memtoreg && EX_regwrite && (EX_wraddr != 5'd0) && (rs_hit || rt_hit);
        br       = EX_branch_taken;
    end

    // Priority memstall > br > lu; a timeout only flushes MEM/WB and leaves
    // the front of the pipe to the branch/load-use logic as usual.
    always_comb begin
        pc_stall    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        stall_memwb = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_memwb = 1'b0;
        dmem_req    = 1'b0;
        if (rst_n) begin
            dmem_req = mem_acc && !timeout;
            if (memstall) begin
                pc_stall    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
                flush_memwb = 1'b1;
            end else begin
                flush_memwb = timeout;
                if (br) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (lu) begin
                    pc_stall   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_acc && !dmem_ack) begin
                        state <= S_WAIT;
                        wcnt  <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state <= S_IDLE;
                        wcnt  <= '0;
                    end else if (at_limit) begin
                        state   <= S_IDLE;
                        wcnt    <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_rs, ID_rt, EX_wraddr;
    logic       ID_uses_rs, ID_uses_rt, EX_memtoreg, EX_regwrite, EX_branch_taken;
    logic       MEM_memread, MEM_memwrite, dmem_ack, cnt_clr;
    logic       pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic       flush_ifid, flush_idex, flush_memwb, dmem_req, bus_err;
    logic [3:0] stall_cnt;
    logic [15:0] outs;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_memtoreg(EX_memtoreg), .EX_regwrite(EX_regwrite), .EX_wraddr(EX_wraddr),
        .EX_branch_taken(EX_branch_taken), .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
        .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_memwb(flush_memwb),
        .dmem_req(dmem_req), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // bit order: pc,s_ifid,s_idex,s_exmem,s_memwb,f_ifid,f_idex,f_memwb,req,berr
    assign outs = {6'b0, pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                   flush_ifid, flush_idex, flush_memwb, dmem_req, bus_err};

    localparam logic [15:0] O_NONE  = 16'b0000000000;
    localparam logic [15:0] O_LU    = 16'b1100001000;
    localparam logic [15:0] O_BR    = 16'b0000011000;
    localparam logic [15:0] O_MSTL  = 16'b1111000110;
    localparam logic [15:0] O_REQ   = 16'b0000000010;
    localparam logic [15:0] O_TOUT  = 16'b0000000100;
    localparam logic [15:0] O_BERR  = 16'b0000000001;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = '0; ID_rt = '0; ID_uses_rs = 0; ID_uses_rt = 0;
        EX_memtoreg = 0; EX_regwrite = 0; EX_wraddr = '0; EX_branch_taken = 0;
        MEM_memread = 0; MEM_memwrite = 0; dmem_ack = 0; cnt_clr = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = rd;
        ID_rs = 5'd5; ID_uses_rs = 1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        MEM_memread = 1;
        set_lu(5'd5);
        #1;
        chk("reset_outs", outs, O_NONE);
        chk("reset_cnt", {12'b0, stall_cnt}, 16'd0);
        tick();
        clear_inputs();
        rst_n = 1;
        tick();

        // load-use on rs
        set_lu(5'd5);
        #1 chk("lu_rs", outs, O_LU);
        tick();
        EX_memtoreg = 0;
        #1 chk("lu_released", outs, O_NONE);
        chk("cnt_lu", {12'b0, stall_cnt}, 16'd1);
        // destination r0 never interlocks
        set_lu(5'd0); ID_rs = 5'd0;
        #1 chk("lu_r0", outs, O_NONE);
        tick();
        // load-use on rt only, then rt not used
        clear_inputs();
        EX_memtoreg = 1; EX_regwrite = 1; EX_wraddr = 5'd7; ID_rt = 5'd7; ID_uses_rt = 1;
        #1 chk("lu_rt", outs, O_LU);
        tick();
        ID_uses_rt = 0;
        #1 chk("lu_rt_unused", outs, O_NONE);
        chk("cnt_lu_rt", {12'b0, stall_cnt}, 16'd2);

        // taken branch masks load-use
        clear_inputs();
        set_lu(5'd5); EX_branch_taken = 1;
        #1 chk("br_over_lu", outs, O_BR);
        tick();
        clear_inputs();
        #1 chk("cnt_after_br", {12'b0, stall_cnt}, 16'd2);

        // load with ack in 4th request cycle
        MEM_memread = 1;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("mem_wait_c%0d", i), outs, O_MSTL);
            tick();
        end
        dmem_ack = 1;
        #1 chk("mem_ack_c4", outs, O_REQ);
        tick();
        clear_inputs();
        #1 chk("cnt_mem", {12'b0, stall_cnt}, 16'd5);

        // reset in the middle of WAIT
        MEM_memread = 1;
        tick();
        tick();
        #1 chk("wait_before_rst", outs, O_MSTL);
        rst_n = 0;
        #1 chk("rst_mid_wait_outs", outs, O_NONE);
        chk("rst_mid_wait_cnt", {12'b0, stall_cnt}, 16'd0);
        tick();
        clear_inputs();
        rst_n = 1;
        #1 chk("after_rst", outs, O_NONE);
        tick();

        // ack exactly at the timeout compare counts as success
        MEM_memread = 1;
        for (int i = 1; i <= 4; i++) begin
            #1 chk($sformatf("late_ack_c%0d", i), outs, O_MSTL);
            tick();
        end
        dmem_ack = 1;
        #1 chk("late_ack_c5", outs, O_REQ);
        tick();
        clear_inputs();
        #1 chk("late_ack_no_err", outs, O_NONE);
        chk("cnt_late_ack", {12'b0, stall_cnt}, 16'd4);

        // timeout: abort in request cycle 5
        MEM_memwrite = 1;
        for (int i = 1; i <= 4; i++) begin
            #1 chk($sformatf("to_c%0d", i), outs, O_MSTL);
            tick();
        end
        #1 chk("to_abort", outs, O_TOUT);
        tick();
        clear_inputs();
        #1 chk("to_berr", outs, O_BERR);
        tick();
        tick();
        #1 chk("to_berr_sticky", outs, O_BERR);
        chk("cnt_to", {12'b0, stall_cnt}, 16'd8);

        // memstall masks branch; branch acts once stall is released
        MEM_memread = 1; EX_branch_taken = 1;
        #1 chk("ms_masks_br", outs, O_MSTL | O_BERR);
        tick();
        dmem_ack = 1;
        #1 chk("br_on_ack", outs, O_BR | O_REQ | O_BERR);
        tick();
        MEM_memread = 0; dmem_ack = 0;
        #1 chk("br_after_ack", outs, O_BR | O_BERR);
        tick();
        clear_inputs();
        #1 chk("cnt_ms_br", {12'b0, stall_cnt}, 16'd9);

        // saturation, then clear with priority over increment
        set_lu(5'd5);
        for (int i = 0; i < 9; i++) tick();
        chk("cnt_sat", {12'b0, stall_cnt}, 16'd15);
        cnt_clr = 1;
        tick();
        chk("cnt_clr", {12'b0, stall_cnt}, 16'd0);
        cnt_clr = 0;
        tick();
        chk("cnt_after_clr", {12'b0, stall_cnt}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
